lsp_cb_search_ctrl: RTL and testbench

LSP_CB_SEARCH_CTRL -- requirements
Module: lsp_cb_search_ctrl

---
 rtl/lsp_cb_search_ctrl.sv | 115 +++++++++++
 tb/tb_lsp_cb_search_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lsp_cb_search_ctrl.sv
// lsp_cb_search_ctrl
// Nearest-entry search of one LSP value against a combinational codebook ROM.
// Each SCAN cycle reads one entry, forms |target - entry| and keeps the
// smallest error seen so far (lower index wins ties).
//
// Optional feature: define CB_SEARCH_EARLY_EXIT_EN to stop the scan as soon
// as the error starts rising (valid for monotone-increasing codebooks).
//
// Ports
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     search request, sampled only in IDLE
//   target    Q15.16 value to quantise, captured on accepted start
//   rom_addr  codebook ROM address
//   rom_data  codebook word for rom_addr (same cycle)
//   busy      search in progress (SCAN and DONE)
//   done      one-cycle completion pulse
//   best_idx  index of nearest entry
//   best_err  unsigned |target - entry| of nearest entry
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for start, rom_addr held at 0
// SCAN  | one codebook entry evaluated per cycle
// DONE  | results final, done pulse, back to IDLE next

module lsp_cb_search_ctrl #(
    parameter int N       = 32,
    parameter int CB_SIZE = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N-1:0]      target,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [N-1:0]      rom_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] best_idx,
    output logic [N-1:0]      best_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [N-1:0]        target_q;
    logic [ADDR_W-1:0]   addr_q;
    logic signed [N:0]   diff;
    logic [N-1:0]        err;
    logic                first_entry;
    logic                last_entry;
    logic                better;
    logic                early_exit;

    // One extra bit keeps the difference of two N-bit signed values exact;
    // its magnitude always fits N bits unsigned.
    assign diff = $signed({target_q[N-1], target_q}) - $signed({rom_data[N-1], rom_data});
    assign err  = diff[N] ? (~diff[N-1:0] + 1'b1) : diff[N-1:0];

    assign first_entry = (addr_q == '0);
    assign last_entry  = (addr_q == ADDR_W'(CB_SIZE - 1));
    assign better      = first_entry || (err < best_err);

`ifdef CB_SEARCH_EARLY_EXIT_EN
    // Error rising past the best means a monotone codebook has moved away.
    assign early_exit = !first_entry && (err > best_err);
`else
    assign early_exit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (last_entry || early_exit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            target_q <= '0;
            addr_q   <= '0;
            best_idx <= '0;
            best_err <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                target_q <= target;
            end
            if (state == SCAN && state_next == SCAN) begin
                addr_q <= addr_q + 1'b1;
            end else begin
                addr_q <= '0;
            end
            if (state == SCAN && better && !early_exit) begin
                best_idx <= addr_q;
                best_err <= err;
            end
        end
    end

    assign rom_addr = addr_q;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_lsp_cb_search_ctrl.sv
module tb_lsp_cb_search_ctrl;

    localparam int N      = 32;
    localparam int ADDR_W = 4;

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [N-1:0]      err;
        int                lat;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [N-1:0]      target;
    logic [ADDR_W-1:0] rom_addr;
    logic [N-1:0]      rom_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] best_idx;
    logic [N-1:0]      best_err;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    // Codebook entry k = (1100 + 100k) in Q15.16.
    assign rom_data = (32'd1100 + 32'd100 * 32'(rom_addr)) << 16;

    lsp_cb_search_ctrl #(.N(N), .CB_SIZE(16), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .target   (target),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy),
        .done     (done),
        .best_idx (best_idx),
        .best_err (best_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Busy-cycle counts (SCAN cycles + DONE cycle), hand-derived per target.
`ifdef CB_SEARCH_EARLY_EXIT_EN
    localparam int LAT_1100 = 3;
    localparam int LAT_1650 = 9;
    localparam int LAT_3000 = 17;
    localparam int LAT_0    = 3;
    localparam int LAT_NEG  = 3;
`else
    localparam int LAT_1100 = 17;
    localparam int LAT_1650 = 17;
    localparam int LAT_3000 = 17;
    localparam int LAT_0    = 17;
    localparam int LAT_NEG  = 17;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: tracks rom_addr sequence and busy length, pops on done.
    initial begin
        int busy_cnt;
        int exp_addr;
        exp_t e;
        busy_cnt = 0;
        exp_addr = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                busy_cnt = 0;
                exp_addr = 0;
            end else if (!busy) begin
                check("idle_rom_addr", 32'(rom_addr), 32'd0);
                busy_cnt = 0;
                exp_addr = 0;
            end else begin
                busy_cnt++;
                if (!done) begin
                    check("scan_rom_addr", 32'(rom_addr), 32'(exp_addr));
                    exp_addr++;
                end else begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=1 required=0");
                    end else begin
                        e = sb.pop_front();
                        check("best_idx", 32'(best_idx), 32'(e.idx));
                        check("best_err", best_err, e.err);
                        check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
                    end
                    busy_cnt = 0;
                    exp_addr = 0;
                end
            end
        end
    end

    task automatic wait_done(output bit ok);
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        ok = done;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 required=1");
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic run_search(input logic [N-1:0] t, input logic [ADDR_W-1:0] idx,
                              input logic [N-1:0] err, input int lat, input bit mid_start);
        exp_t e;
        bit ok;
        e.idx = idx;
        e.err = err;
        e.lat = lat;
        sb.push_back(e);
        target = t;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (mid_start) begin
            repeat (4) @(negedge clk);
            target = 32'd1100 << 16;
            start  = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(ok);
        if (ok) begin
            // start during the DONE cycle must not launch a new search
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_in_done_ignored", 32'(busy), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        target = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_best_idx", 32'(best_idx), 32'd0);
        check("reset_best_err", best_err, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_search(32'd1100 << 16, 4'd0,  32'h0000_0000, LAT_1100, 1'b0);
        run_search(32'd1650 << 16, 4'd5,  32'h0032_0000, LAT_1650, 1'b0);
        run_search(32'd3000 << 16, 4'd15, 32'h0190_0000, LAT_3000, 1'b0);
        run_search(32'd0,          4'd0,  32'h044C_0000, LAT_0,    1'b0);
        run_search(32'hFFFF_0000,  4'd0,  32'h044D_0000, LAT_NEG,  1'b0);
        // start pulsed mid-scan with a different target: must be ignored
        run_search(32'd3000 << 16, 4'd15, 32'h0190_0000, LAT_3000, 1'b1);

        // Reset abort in the middle of a scan.
        target = 32'd3000 << 16;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        target = 32'd1100 << 16;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rom_addr", 32'(rom_addr), 32'd0);
        check("abort_best_idx", 32'(best_idx), 32'd0);
        check("abort_best_err", best_err, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_abort_idle", 32'(busy), 32'd0);
        check("post_abort_no_done", 32'(done), 32'd0);

        run_search(32'd1650 << 16, 4'd5, 32'h0032_0000, LAT_1650, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
